pll_lock_sequencer: RTL



---
 rtl/pll_lock_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: resets the video PLL, waits for lock, qualifies it, re-sequences on loss.
// Ports: refclk, rst_n, pll_locked (async), restart -> pll_rst, ready, fault, lock_loss_count, state.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_LOCK  = 3'd1,
    STABLE     = 3'd2,
    RUN        = 3'd3,
    FAULT      = 3'd4
  } state_e;

  localparam int RW = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES) : 1;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);

  logic [2:0]       state_q;
  logic [CNT_W-1:0] timer_q;
  logic [RW-1:0]    retry_cnt;
  logic             sync1_q;
  logic             locked_s;
  logic             last_try;

  assign last_try = (int'(retry_cnt) + 1) == MAX_RETRIES;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1_q  <= pll_locked;
      locked_s <= sync1_q;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= RESET_HOLD;
      timer_q         <= '0;
      retry_cnt       <= '0;
      lock_loss_count <= '0;
    end else begin
      timer_q <= timer_q + 1'b1;
      if (restart) begin
        state_q   <= RESET_HOLD;
        timer_q   <= '0;
        retry_cnt <= '0;
      end else begin
        case (state_q)
          RESET_HOLD: begin
            if (timer_q == RST_LAST) begin
              state_q <= WAIT_LOCK;
              timer_q <= '0;
            end
          end
          WAIT_LOCK: begin
            if (locked_s) begin
              state_q <= STABLE;
              timer_q <= '0;
            end else if (timer_q == LOCK_LAST) begin
              timer_q <= '0;
              if (last_try) begin
                state_q <= FAULT;
              end else begin
                state_q   <= RESET_HOLD;
                retry_cnt <= retry_cnt + 1'b1;
              end
            end
          end
          STABLE: begin
            if (!locked_s) begin
              timer_q <= '0;
              if (last_try) begin
                state_q <= FAULT;
              end else begin
                state_q   <= RESET_HOLD;
                retry_cnt <= retry_cnt + 1'b1;
              end
            end else if (timer_q == STB_LAST) begin
              state_q   <= RUN;
              timer_q   <= '0;
              retry_cnt <= '0;
            end
          end
          RUN: begin
            if (!locked_s) begin
              if (lock_loss_count != 8'hFF)
                lock_loss_count <= lock_loss_count + 8'd1;
              retry_cnt <= '0;
              state_q   <= RESET_HOLD;
              timer_q   <= '0;
            end
          end
          FAULT: state_q <= FAULT;
          default: begin
            state_q <= RESET_HOLD;
            timer_q <= '0;
          end
        endcase
      end
    end
  end

  // Decoded straight from the state register so reset takes effect asynchronously.
  assign pll_rst = (state_q == RESET_HOLD) || (state_q == FAULT);
  assign ready   = (state_q == RUN);
  assign fault   = (state_q == FAULT);
  assign state   = state_q;

endmodule
